// File: rtl/seq_mini_alu.sv
// Registered mini ALU: add/sub complete in one cycle, shifts iterate one bit per cycle.
// Valid/ready handshakes on both the operand and result sides.
module seq_mini_alu #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RES_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             operation,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             zero,
    output logic             borrow,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(RES_W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               borrow_q, borrow_d;

    logic [RES_W-1:0]   op1_ext;
    logic [RES_W-1:0]   op2_ext;
    logic [RES_W-1:0]   shifted;
    logic [CNT_W-1:0]   shift_amt;

    assign op1_ext = RES_W'(op1);
    assign op2_ext = RES_W'(op2);
    assign shifted = dir_q ? (acc_q >> 1) : (acc_q << 1);

    // Shift amounts at or beyond RES_W saturate: RES_W steps already clear acc.
    always_comb begin
        if (32'(op2) >= RES_W) begin
            shift_amt = CNT_W'(RES_W);
        end else begin
            shift_amt = CNT_W'(op2);
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        result_d = result_q;
        zero_d   = zero_q;
        borrow_d = borrow_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    borrow_d = 1'b0;
                    if (!operation) begin
                        if (sign) begin
                            result_d = op1_ext - op2_ext;
                            borrow_d = (op2 > op1);
                        end else begin
                            result_d = op1_ext + op2_ext;
                        end
                        zero_d  = (result_d == '0);
                        state_d = StDone;
                    end else if (shift_amt == '0) begin
                        result_d = op1_ext;
                        zero_d   = (op1_ext == '0);
                        state_d  = StDone;
                    end else begin
                        acc_d   = op1_ext;
                        cnt_d   = shift_amt;
                        dir_d   = sign;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                acc_d = shifted;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            borrow_q <= borrow_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;
    assign zero      = zero_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_seq_mini_alu.sv
// Scoreboard bench for seq_mini_alu: driver pushes model predictions, monitor pops on out_valid.
module tb_seq_mini_alu;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RES_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] op1 = '0;
    logic [WIDTH-1:0] op2 = '0;
    logic             operation = 1'b0;
    logic             sign = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [RES_W-1:0] result;
    logic             zero;
    logic             borrow;
    logic             busy;

    seq_mini_alu #(.WIDTH(WIDTH), .RES_W(RES_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .operation (operation),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .borrow    (borrow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RES_W-1:0] res;
        logic             zf;
        logic             bf;
        int               due;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rand_bp = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference model straight from the arithmetic rules, not from the datapath.
    function automatic exp_t model(input int unsigned a, input int unsigned b,
                                   input bit o, input bit s, input int acc_cyc);
        exp_t   e;
        longint mask = (longint'(1) << RES_W) - 1;
        longint r;
        int     k = (b > RES_W) ? RES_W : b;
        if (!o) begin
            r = s ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
            e.bf = s && (b > a);
            e.due = acc_cyc + 1;
        end else begin
            if (s) r = longint'(a) >> k;
            else if (k >= RES_W) r = 0;
            else r = longint'(a) << k;
            e.bf = 1'b0;
            e.due = acc_cyc + 1 + k;
        end
        r = r & mask;
        e.res = RES_W'(r);
        e.zf = (r == 0);
        return e;
    endfunction

    task automatic issue(input int unsigned a, input int unsigned b, input bit o, input bit s);
        int n = 0;
        @(negedge clk);
        op1 = WIDTH'(a);
        op2 = WIDTH'(b);
        operation = o;
        sign = s;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            expq.push_back(model(a, b, o, s, cyc));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit check_busy);
        int n = 0;
        while (!out_valid && n < 200) begin
            if (check_busy) begin
                check("busy_during_op", busy, 1);
                check("in_ready_during_op", in_ready, 0);
            end
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("done_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) check("drain_timeout", expq.size(), 0);
    endtask

    // Monitor: first cycle of each out_valid window pops one prediction; later cycles check hold.
    logic             seen = 1'b0;
    logic [RES_W-1:0] held_res;
    logic             held_z;
    logic             held_b;
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (in_ready && out_valid) begin
                failures++;
                $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 required not both");
            end
        end
        if (out_valid && !seen) begin
            seen = 1'b1;
            held_res = result;
            held_z = zero;
            held_b = borrow;
            if (expq.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("result", result, e.res);
                check("zero", zero, e.zf);
                check("borrow", borrow, e.bf);
                check("latency_cycle", cyc, e.due);
            end
        end else if (out_valid) begin
            check("hold_result", result, held_res);
            check("hold_flags", {zero, borrow}, {held_z, held_b});
        end
        if (!out_valid) seen = 1'b0;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2;
        check("rst_result", result, 0);
        check("rst_flags", {zero, borrow, out_valid, busy}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // Directed cases from the plan
        issue(200, 100, 0, 0);
        issue(5, 9, 0, 1);
        issue(9, 9, 0, 1);
        issue(8'hFF, 3, 1, 0);
        wait_done(1'b1);
        issue(8'hFF, 40, 1, 0);
        issue(8'h80, 7, 1, 1);
        issue(8'hA5, 0, 1, 0);
        issue(8'hA5, 0, 1, 1);
        issue(0, 0, 0, 0);
        drain();

        // Backpressure: result held, new operands ignored until consumer accepts
        out_ready = 1'b0;
        issue(10, 20, 0, 0);
        wait_done(1'b0);
        for (int i = 0; i < 5; i++) begin
            op1 = WIDTH'($urandom);
            op2 = WIDTH'($urandom);
            operation = 1'b0;
            in_valid = ~in_valid;
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        issue(3, 4, 0, 0);
        drain();

        // Async reset in the middle of a shift aborts it silently
        issue(1, 20, 1, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_result", result, 0);
        check("arst_flags", {out_valid, busy, zero, borrow}, 4'b0000);
        expq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_in_ready", in_ready, 1);
        repeat (40) @(negedge clk);

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int unsigned a = $urandom_range(0, 255);
            int unsigned b = $urandom_range(0, 255);
            bit o = 1'($urandom);
            bit s = 1'($urandom);
            if (o && $urandom_range(0, 3) != 0) b = $urandom_range(0, 40);
            if ($urandom_range(0, 7) == 0) b = a;
            issue(a, b, o, s);
        end
        drain();
        rand_bp = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
